rgb_pwm_core: RTL

- PWM engine directly downstream of the rgb_led_ctrl AXI4-Lite register slave.
- Consumes the four 32-bit slave registers (reg0 control, reg1 duty, reg2 prescaler, reg3 blink) and drives the three physical LED pins.
- Duty values are shadowed and applied only at PWM period boundaries, so there are no glitches.
- Optional blink sequencing is counted in whole PWM periods.

---
 rtl/rgb_led_pkg.sv | 33 +++
 rtl/rgb_pwm_chan.sv | 43 ++++
 rtl/rgb_pwm_core.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rgb_led_pkg.sv
// Shared types and register/status field positions for the RGB LED PWM engine.
// Also holds the helper that turns a raw blink length field into a period count.
package rgb_led_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    BLINK_ON  = 2'd2,
    BLINK_OFF = 2'd3
  } state_t;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLINK_BIT = 1;

  localparam int DUTY_W     = 8;
  localparam int DUTY_R_OFS = 0;
  localparam int DUTY_G_OFS = 8;
  localparam int DUTY_B_OFS = 16;

  localparam int BLINK_W       = 16;
  localparam int BLINK_ON_OFS  = 0;
  localparam int BLINK_OFF_OFS = 16;

  localparam int STAT_STATE_OFS = 0;
  localparam int STAT_CNT_OFS   = 8;
  localparam int STAT_PEND_BIT  = 16;

  // A programmed length of zero still lasts one period.
  function automatic logic [BLINK_W-1:0] blink_len(input logic [BLINK_W-1:0] field);
    return (field == '0) ? BLINK_W'(1) : field;
  endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One colour channel: duty shadow register, counter compare and registered LED drive.
// The shadow only changes when load_i is asserted, keeping each period glitch-free.
module rgb_pwm_chan
  import rgb_led_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              active_i,
  output logic              led_o
);

  localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic              led_q, led_d;
  logic [CMP_W-1:0]  cnt_ext, duty_ext;

  assign cnt_ext  = CMP_W'(cnt_i);
  assign duty_ext = CMP_W'(shadow_q);

  always_comb begin
    shadow_d = load_i ? duty_i : shadow_q;
    led_d    = active_i && (cnt_ext < duty_ext);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/rgb_pwm_core.sv
// PWM engine behind the RGB LED register slave: prescaler, period counter,
// blink sequencer FSM and three shadowed compare channels.
module rgb_pwm_core
  import rgb_led_pkg::*;
#(
  parameter int       CNT_W      = 8,
  parameter int       PRESC_W    = 16,
  parameter bit       ACTIVE_LOW = 1'b0
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] ctrl_reg,
  input  logic [31:0] duty_reg,
  input  logic [31:0] presc_reg,
  input  logic [31:0] blink_reg,
  input  logic        reg_update,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        period_tick,
  output logic [31:0] status
);

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]     pwm_q, pwm_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 pending_q, pending_d;
  logic                 period_tick_q;

  logic                 enable, blink_en, running, tick, period_end;
  logic                 shadow_load, led_active;
  logic [PRESC_W-1:0]   presc_val;
  logic [BLINK_W-1:0]   on_len, off_len, blink_next;
  logic                 led_r_q, led_g_q, led_b_q;
  logic [31:0]          pwm_ext;

  logic unused_reg_bits;
  assign unused_reg_bits = ^{ctrl_reg[31:2], presc_reg[31:PRESC_W], duty_reg[31:24]};

  assign enable    = ctrl_reg[CTRL_EN_BIT];
  assign blink_en  = ctrl_reg[CTRL_BLINK_BIT];
  assign presc_val = presc_reg[PRESC_W-1:0];
  assign on_len    = blink_len(blink_reg[BLINK_ON_OFS +: BLINK_W]);
  assign off_len   = blink_len(blink_reg[BLINK_OFF_OFS +: BLINK_W]);

  // '>=' rather than '==' so a prescale value lowered below the count wraps at once.
  assign running    = (state_q != IDLE);
  assign tick       = running && (presc_q >= presc_val);
  assign period_end = tick && (pwm_q == '1);
  assign blink_next = blink_cnt_q + BLINK_W'(1);

  always_comb begin
    presc_d = presc_q;
    pwm_d   = pwm_q;
    if (!enable || !running) begin
      presc_d = '0;
      pwm_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      pwm_d   = pwm_q + CNT_W'(1);
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // In IDLE the shadows follow duty_reg directly; otherwise only at a boundary.
  always_comb begin
    shadow_load = (state_q == IDLE) || (period_end && (pending_q || reg_update));
    pending_d   = pending_q;
    if (state_q == IDLE || shadow_load) begin
      pending_d = 1'b0;
    end else if (reg_update) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      pwm_q         <= '0;
      blink_cnt_q   <= '0;
      pending_q     <= 1'b0;
      period_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      pwm_q         <= pwm_d;
      blink_cnt_q   <= blink_cnt_d;
      pending_q     <= pending_d;
      period_tick_q <= period_end;
    end
  end

  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    if (!enable) begin
      state_d     = IDLE;
      blink_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = blink_en ? BLINK_ON : RUN;
          blink_cnt_d = '0;
        end
        RUN: begin
          if (period_end && blink_en) begin
            state_d     = BLINK_ON;
            blink_cnt_d = '0;
          end
        end
        BLINK_ON: begin
          if (period_end) begin
            if (!blink_en) begin
              state_d     = RUN;
              blink_cnt_d = '0;
            end else if (blink_next >= on_len) begin
              state_d     = BLINK_OFF;
              blink_cnt_d = '0;
            end else begin
              blink_cnt_d = blink_next;
            end
          end
        end
        BLINK_OFF: begin
          if (period_end) begin
            if (!blink_en) begin
              state_d     = RUN;
              blink_cnt_d = '0;
            end else if (blink_next >= off_len) begin
              state_d     = BLINK_ON;
              blink_cnt_d = '0;
            end else begin
              blink_cnt_d = blink_next;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          blink_cnt_d = '0;
        end
      endcase
    end
  end

  // Gated by enable too, so a disable darkens the pins on the very next edge.
  always_comb begin
    led_active = enable && (state_q == RUN || state_q == BLINK_ON);
    pwm_ext    = 32'(pwm_q);
    status     = '0;
    status[STAT_STATE_OFS +: 2] = state_q;
    status[STAT_CNT_OFS +: 8]   = pwm_ext[7:0];
    status[STAT_PEND_BIT]       = pending_q;
  end

  rgb_pwm_chan #(.CNT_W(CNT_W)) u_chan_r (
    .clk_i    (ACLK),
    .rst_ni   (ARESETN),
    .load_i   (shadow_load),
    .duty_i   (duty_reg[DUTY_R_OFS +: DUTY_W]),
    .cnt_i    (pwm_q),
    .active_i (led_active),
    .led_o    (led_r_q)
  );

  rgb_pwm_chan #(.CNT_W(CNT_W)) u_chan_g (
    .clk_i    (ACLK),
    .rst_ni   (ARESETN),
    .load_i   (shadow_load),
    .duty_i   (duty_reg[DUTY_G_OFS +: DUTY_W]),
    .cnt_i    (pwm_q),
    .active_i (led_active),
    .led_o    (led_g_q)
  );

  rgb_pwm_chan #(.CNT_W(CNT_W)) u_chan_b (
    .clk_i    (ACLK),
    .rst_ni   (ARESETN),
    .load_i   (shadow_load),
    .duty_i   (duty_reg[DUTY_B_OFS +: DUTY_W]),
    .cnt_i    (pwm_q),
    .active_i (led_active),
    .led_o    (led_b_q)
  );

  assign led_r       = led_r_q ^ ACTIVE_LOW;
  assign led_g       = led_g_q ^ ACTIVE_LOW;
  assign led_b       = led_b_q ^ ACTIVE_LOW;
  assign period_tick = period_tick_q;

endmodule
